// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, word-addressed data memory between the
//   instruction-fetch port (IF) and the load/store port (D). A request is
//   accepted on valid&ready, the winner's fields are latched and drive the
//   memory for exactly one cycle (ACCESS). The response pulse goes back to
//   that requester only, in the following cycle (RESP). A new request may be
//   accepted in RESP, giving one transaction every two cycles.
//
//   Conflict resolution (both ports valid in an accepting cycle):
//     default            : D wins, unless IF has lost MAX_WAIT times in a row.
//     MEM_ARB_RR_EN set  : round-robin, the previous owner loses.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req_valid/ready, if_addr  IF read request
//   if_rsp_valid, if_rdata       IF response (one-cycle pulse, data held)
//   d_req_valid/ready, d_addr,
//   d_we, d_wdata, d_type        D load/store request
//   d_rsp_valid, d_rdata         D response (rdata is 0 for stores)
//   mem_addr, mem_is_store,
//   mem_wdata, mem_type          memory command, non-zero only in ACCESS
//   mem_loaddata                 combinational read data from memory
//
// Configuration macro: MEM_ARB_RR_EN (round-robin arbitration when defined)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_type,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_is_store,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_type,
    input  logic [31:0]       mem_loaddata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic OWN_IF = 1'b1;
    localparam logic OWN_D  = 1'b0;
    localparam logic [2:0] IF_TYPE = 3'b010;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accepting;
    logic              w_if_win;
    logic              w_d_win;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [2:0]        r_type;
    logic              r_owner;
    logic              r_if_rsp_valid;
    logic              r_d_rsp_valid;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;

`ifdef MEM_ARB_RR_EN
    logic              r_last_owner;
`else
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    logic [CNT_W-1:0]  r_wait_cnt;
`endif

    // Reset blocks acceptance so nothing is granted while the block is cleared.
    assign w_accepting = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !rst;

    // Arbitration: pick at most one winner among the valid requesters.
    always_comb begin
        w_if_win = 1'b0;
        w_d_win  = 1'b0;
        if (w_accepting) begin
            if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
                if (r_last_owner == OWN_IF) begin
                    w_d_win = 1'b1;
                end else begin
                    w_if_win = 1'b1;
                end
`else
                if (r_wait_cnt == MAX_WAIT_C) begin
                    w_if_win = 1'b1;
                end else begin
                    w_d_win = 1'b1;
                end
`endif
            end else begin
                w_if_win = if_req_valid;
                w_d_win  = d_req_valid;
            end
        end else begin
            w_if_win = 1'b0;
            w_d_win  = 1'b0;
        end
    end

    assign if_req_ready = w_if_win;
    assign d_req_ready  = w_d_win;

    // Next-state logic for the IDLE/ACCESS/RESP sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_if_win || w_d_win) begin
                    w_state_next = ST_ACCESS;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_next = ST_RESP;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin history: starts as IF so D takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_IF;
        end else if (w_if_win) begin
            r_last_owner <= OWN_IF;
        end else if (w_d_win) begin
            r_last_owner <= OWN_D;
        end else begin
            r_last_owner <= r_last_owner;
        end
    end
`else
    // IF starvation counter: counts accepting cycles IF lost, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_if_win) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_d_win && if_req_valid && (r_wait_cnt != MAX_WAIT_C)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`endif

    // Transaction latches, response pulses and per-port read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= {ADDR_W{1'b0}};
            r_we           <= 1'b0;
            r_wdata        <= 32'h0000_0000;
            r_type         <= 3'b000;
            r_owner        <= OWN_D;
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_if_rdata     <= 32'h0000_0000;
            r_d_rdata      <= 32'h0000_0000;
        end else begin
            if (w_if_win) begin
                r_addr  <= if_addr;
                r_we    <= 1'b0;
                r_wdata <= 32'h0000_0000;
                r_type  <= IF_TYPE;
                r_owner <= OWN_IF;
            end else if (w_d_win) begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
                r_type  <= d_type;
                r_owner <= OWN_D;
            end
            r_if_rsp_valid <= (r_state == ST_ACCESS) && (r_owner == OWN_IF);
            r_d_rsp_valid  <= (r_state == ST_ACCESS) && (r_owner == OWN_D);
            // Memory read data is valid at the end of ACCESS; only the owner's
            // register is updated, the other port keeps its last value.
            if (r_state == ST_ACCESS) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_loaddata;
                end else begin
                    r_d_rdata <= r_we ? 32'h0000_0000 : mem_loaddata;
                end
            end
        end
    end

    assign if_rsp_valid = r_if_rsp_valid;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;

    // Memory command decode: driven only from registers, and only in ACCESS,
    // so a store started in ACCESS always sees a stable command at negedge.
    always_comb begin
        mem_addr     = {ADDR_W{1'b0}};
        mem_is_store = 1'b0;
        mem_wdata    = 32'h0000_0000;
        mem_type     = 3'b000;
        if (r_state == ST_ACCESS) begin
            mem_addr     = r_addr;
            mem_is_store = r_we;
            mem_wdata    = r_wdata;
            mem_type     = r_type;
        end else begin
            mem_addr     = {ADDR_W{1'b0}};
            mem_is_store = 1'b0;
            mem_wdata    = 32'h0000_0000;
            mem_type     = 3'b000;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [31:0]       if_rdata;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [31:0]       d_wdata;
    logic [2:0]        d_type;
    logic              d_rsp_valid;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_is_store;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_type;
    logic [31:0]       mem_loaddata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_type(d_type),
        .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_is_store(mem_is_store), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_loaddata(mem_loaddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, store on negedge, preloadable.
    logic [31:0] mem [0:DEPTH-1];
    logic        preload;

    function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
        if (a == 14'h0010) return 32'h0050_0093;
        return {2'b10, 16'hC0DE, a};
    endfunction

    assign mem_loaddata = mem[mem_addr];

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(ADDR_W'(i));
        end else if (mem_is_store) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_we         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- random-phase reference model ----------------
    typedef struct {
        bit                is_if;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [2:0]        typ;
        logic [31:0]       rdata;
        int                acc_cyc;
    } txn_t;

    txn_t        q[$];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          cyc;
    int          m_wait;
    bit          m_last_if;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;

    // One random cycle: memory is busy in the cycle after each accept, the
    // response arrives the cycle after that.
    task automatic rand_cycle();
        bit   in_acc, in_rsp, accepting, exp_if, exp_d;
        txn_t acc, rsp, t;
        in_acc = 1'b0;
        in_rsp = 1'b0;
        foreach (q[i]) begin
            if (q[i].acc_cyc == cyc) begin in_acc = 1'b1; acc = q[i]; end
            if (q[i].acc_cyc + 1 == cyc) begin in_rsp = 1'b1; rsp = q[i]; end
        end
        rst          = ($urandom_range(0, 49) == 0);
        if_req_valid = ($urandom_range(0, 9) < 6);
        d_req_valid  = ($urandom_range(0, 9) < 6);
        if_addr      = ADDR_W'($urandom_range(0, 31));
        d_addr       = ADDR_W'($urandom_range(0, 31));
        d_we         = $urandom_range(0, 1) == 1;
        d_wdata      = $urandom;
        d_type       = 3'($urandom_range(0, 7));
        accepting = !in_acc && !rst;
        exp_if = 1'b0;
        exp_d  = 1'b0;
        if (accepting) begin
            if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
                if (m_last_if) exp_d = 1'b1; else exp_if = 1'b1;
`else
                if (m_wait >= MAX_WAIT) exp_if = 1'b1; else exp_d = 1'b1;
`endif
            end else begin
                exp_if = if_req_valid;
                exp_d  = d_req_valid;
            end
        end
        @(negedge clk);
        chk("rnd if_req_ready", 32'(if_req_ready), 32'(exp_if));
        chk("rnd d_req_ready", 32'(d_req_ready), 32'(exp_d));
        if (in_acc) begin
            chk("rnd mem_addr", 32'(mem_addr), 32'(acc.addr));
            chk("rnd mem_is_store", 32'(mem_is_store), 32'(acc.we));
            chk("rnd mem_type", 32'(mem_type), 32'(acc.typ));
            if (!acc.is_if) chk("rnd mem_wdata", mem_wdata, acc.wdata);
        end else begin
            chk("rnd idle mem_cmd", {mem_wdata[31:18] | 14'(mem_addr), mem_wdata[17:0]} | 32'(mem_type) | 32'(mem_is_store), 32'h0);
        end
        chk("rnd if_rsp_valid", 32'(if_rsp_valid), 32'(in_rsp && rsp.is_if));
        chk("rnd d_rsp_valid", 32'(d_rsp_valid), 32'(in_rsp && !rsp.is_if));
        chk("rnd if_rdata", if_rdata, m_if_rdata);
        chk("rnd d_rdata", d_rdata, m_d_rdata);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_wait     = 0;
            m_last_if  = 1'b1;
            m_if_rdata = 32'h0;
            m_d_rdata  = 32'h0;
        end else begin
            if (in_acc) begin
                if (acc.is_if) m_if_rdata = acc.rdata; else m_d_rdata = acc.rdata;
            end
            if (exp_if || exp_d) begin
                t.is_if   = exp_if;
                t.we      = exp_d && d_we;
                t.addr    = exp_if ? if_addr : d_addr;
                t.wdata   = d_wdata;
                t.typ     = exp_if ? 3'b010 : d_type;
                t.rdata   = t.we ? 32'h0 : ref_mem[t.addr];
                t.acc_cyc = cyc + 1;
                if (t.we) ref_mem[t.addr] = t.wdata;
                q.push_back(t);
                m_last_if = exp_if;
            end
            if (exp_if) m_wait = 0;
            else if (exp_d && if_req_valid && m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
        cyc++;
        while (q.size() > 0 && q[0].acc_cyc + 1 < cyc) void'(q.pop_front());
        #1;
    endtask

    // ---------------- conflict table ----------------
    typedef struct {
        bit                ifr;
        bit                dr;
        bit                ifrsp;
        bit                drsp;
        logic [ADDR_W-1:0] maddr;
    } vec_t;

    vec_t vt[21];
    bit   g_if[11];

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_c[$];
        int rsp_c[$];
        logic [31:0] rsp_d[$];

        // Expected grant sequence for both ports valid continuously.
        for (int k = 0; k < 11; k++) begin
`ifdef MEM_ARB_RR_EN
            g_if[k] = (k % 2 == 1);
`else
            g_if[k] = (k == 4) || (k == 9);
`endif
        end
        for (int c = 0; c < 21; c++) vt[c] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h0000};
        for (int k = 0; k < 11; k++) begin
            vt[2*k].ifr = g_if[k];
            vt[2*k].dr  = !g_if[k];
            if (2*k + 1 < 21) vt[2*k+1].maddr = g_if[k] ? 14'h0010 : 14'h0011;
            if (2*k + 2 < 21) begin
                vt[2*k+2].ifrsp = g_if[k];
                vt[2*k+2].drsp  = !g_if[k];
            end
        end

        if_addr = 14'h0000; d_addr = 14'h0000; d_wdata = 32'h0; d_type = 3'b000;
        preload = 1'b1;
        do_reset();
        preload = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset ready", 32'({if_req_ready, d_req_ready}), 32'h0);
        chk("reset rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), 32'h0);
        chk("reset rdata", if_rdata | d_rdata, 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        tick();

        // IF-only fetch.
        if_req_valid = 1'b1; if_addr = 14'h0010;
        @(negedge clk);
        chk("t1 if_req_ready", 32'(if_req_ready), 32'h1);
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        chk("t1 mem_addr", 32'(mem_addr), 32'h10);
        chk("t1 mem_type", 32'(mem_type), 32'h2);
        chk("t1 early rsp", 32'(if_rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("t1 if_rsp_valid", 32'(if_rsp_valid), 32'h1);
        chk("t1 if_rdata", if_rdata, 32'h0050_0093);
        chk("t1 d_rsp_valid", 32'(d_rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("t1 rsp one cycle", 32'(if_rsp_valid), 32'h0);
        chk("t1 rdata held", if_rdata, 32'h0050_0093);
        tick();

        // D store then D load of the same word.
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 14'h0020; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
        @(negedge clk);
        chk("t2 st ready", 32'(d_req_ready), 32'h1);
        tick();
        d_req_valid = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("t2 st mem_is_store", 32'(mem_is_store), 32'h1);
        chk("t2 st mem_addr", 32'(mem_addr), 32'h20);
        chk("t2 st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        d_req_valid = 1'b1; d_we = 1'b0;
        @(negedge clk);
        chk("t2 st rsp", 32'(d_rsp_valid), 32'h1);
        chk("t2 st rdata", d_rdata, 32'h0);
        chk("t2 resp is_store", 32'(mem_is_store), 32'h0);
        chk("t2 ld ready in resp", 32'(d_req_ready), 32'h1);
        tick();
        d_req_valid = 1'b0;
        @(negedge clk);
        chk("t2 ld mem_is_store", 32'(mem_is_store), 32'h0);
        tick();
        @(negedge clk);
        chk("t2 ld rsp", 32'(d_rsp_valid), 32'h1);
        chk("t2 ld rdata", d_rdata, 32'hDEAD_BEEF);
        tick();
        tick();

        // Back-to-back D loads with valid held.
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 14'h0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (d_req_valid && d_req_ready) acc_c.push_back(c);
            if (d_rsp_valid) begin rsp_c.push_back(c); rsp_d.push_back(d_rdata); end
            tick();
            if (acc_c.size() == 2) d_req_valid = 1'b0;
        end
        chk("t6 accept count", 32'(acc_c.size()), 32'd2);
        chk("t6 rsp count", 32'(rsp_c.size()), 32'd2);
        if (acc_c.size() == 2 && rsp_c.size() == 2) begin
            chk("t6 accept gap", 32'(acc_c[1] - acc_c[0]), 32'd2);
            chk("t6 rsp gap", 32'(rsp_c[1] - rsp_c[0]), 32'd2);
            chk("t6 latency", 32'(rsp_c[0] - acc_c[0]), 32'd2);
            chk("t6 rdata", rsp_d[1], 32'h0050_0093);
        end

        // Reset at the edge that ends a D load's ACCESS.
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 14'h0020;
        @(negedge clk);
        chk("t5 ready", 32'(d_req_ready), 32'h1);
        tick();
        d_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t5 access addr", 32'(mem_addr), 32'h20);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 no rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'h0);
        chk("t5 ready 0", 32'({if_req_ready, d_req_ready}), 32'h0);
        chk("t5 rdata 0", if_rdata | d_rdata, 32'h0);
        chk("t5 mem 0", mem_wdata | 32'(mem_addr) | 32'(mem_type) | 32'(mem_is_store), 32'h0);
        tick();
        if_req_valid = 1'b1; if_addr = 14'h0010;
        @(negedge clk);
        chk("t5 if ready", 32'(if_req_ready), 32'h1);
        tick();
        if_req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t5 if rsp", 32'(if_rsp_valid), 32'h1);
        chk("t5 if rdata", if_rdata, 32'h0050_0093);
        tick();

        // Both ports valid continuously: grant order from the table.
        do_reset();
        if_req_valid = 1'b1; if_addr = 14'h0010;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 14'h0011;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            chk($sformatf("t3 c%0d if_ready", c), 32'(if_req_ready), 32'(vt[c].ifr));
            chk($sformatf("t3 c%0d d_ready", c), 32'(d_req_ready), 32'(vt[c].dr));
            chk($sformatf("t3 c%0d if_rsp", c), 32'(if_rsp_valid), 32'(vt[c].ifrsp));
            chk($sformatf("t3 c%0d d_rsp", c), 32'(d_rsp_valid), 32'(vt[c].drsp));
            chk($sformatf("t3 c%0d mem_addr", c), 32'(mem_addr), 32'(vt[c].maddr));
            tick();
        end

        // Randomized traffic against the reference model.
        idle_inputs();
        preload = 1'b1;
        do_reset();
        preload = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(ADDR_W'(i));
        q.delete();
        cyc = 0; m_wait = 0; m_last_if = 1'b1; m_if_rdata = 32'h0; m_d_rdata = 32'h0;
        for (int n = 0; n < 600; n++) rand_cycle();
        rst = 1'b0;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
